// File: rtl/dma_service_scheduler.sv
// DMA channel scheduler: DREQ arbitration, HRQ/HLDA hold handshake,
// one registered DACK per service period, mode-based release, rotating priority.
// Optional build macro: DREQ_SYNC_EN adds a 2-flop DREQ synchronizer.
// Ports: CLK, RESET_N (async, active low); DREQ, maskReg, priorityType,
//   modeReg, HLDA, cycleDone, tcReached in; HRQ, DACK, activeCh, chValid out.
module dma_service_scheduler #(
  parameter  int NUM_CH = 4,
  localparam int CHW    = $clog2(NUM_CH)
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [NUM_CH-1:0]   DREQ,
  input  logic [NUM_CH-1:0]   maskReg,
  input  logic                priorityType,
  input  logic [2*NUM_CH-1:0] modeReg,
  input  logic                HLDA,
  input  logic                cycleDone,
  input  logic                tcReached,
  output logic                HRQ,
  output logic [NUM_CH-1:0]   DACK,
  output logic [CHW-1:0]      activeCh,
  output logic                chValid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    GRANT = 2'd2
  } stateT;

  stateT state;
  stateT stateNext;

  logic [NUM_CH-1:0] dreqEff;
  logic [NUM_CH-1:0] req;

`ifdef DREQ_SYNC_EN
  logic [NUM_CH-1:0] dreqMeta;
  logic [NUM_CH-1:0] dreqSync;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      dreqMeta <= '0;
      dreqSync <= '0;
    end else begin
      dreqMeta <= DREQ;
      dreqSync <= dreqMeta;
    end
  end

  assign dreqEff = dreqSync;
`else
  assign dreqEff = DREQ;
`endif

  assign req = dreqEff & ~maskReg;

  // hiPtr is the current highest-priority channel in rotating mode
  logic [CHW-1:0]    hiPtr;
  logic [CHW-1:0]    hiPtrNext;
  logic [CHW-1:0]    base;
  logic [CHW-1:0]    idx;
  logic [CHW-1:0]    winner;
  logic              winValid;
  logic [1:0]        modeCur;
  logic              relNow;
  logic              rotate;
  logic              hrqNext;
  logic [NUM_CH-1:0] dackNext;
  logic [CHW-1:0]    activeChNext;
  logic              chValidNext;

  // Scan from the top-priority channel, wrapping modulo NUM_CH
  always_comb begin
    base     = priorityType ? hiPtr : '0;
    idx      = '0;
    winner   = '0;
    winValid = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = base + CHW'(i);
      if (!winValid && req[idx]) begin
        winner   = idx;
        winValid = 1'b1;
      end
    end
  end

  // Release decision for the channel in service; demand mode
  // looks at raw DREQ so a mask change does not end the service
  always_comb begin
    modeCur = modeReg[{activeCh, 1'b0} +: 2];
    relNow  = 1'b1;
    unique case (1'b1)
      (modeCur == 2'b00): relNow = tcReached || !dreqEff[activeCh];
      (modeCur == 2'b10): relNow = tcReached;
      default:            relNow = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      HRQ      <= 1'b0;
      DACK     <= '0;
      activeCh <= '0;
      chValid  <= 1'b0;
      hiPtr    <= '0;
    end else begin
      state    <= stateNext;
      HRQ      <= hrqNext;
      DACK     <= dackNext;
      activeCh <= activeChNext;
      chValid  <= chValidNext;
      hiPtr    <= hiPtrNext;
    end
  end

  // Abort (HLDA low) takes precedence over cycleDone in GRANT
  always_comb begin
    stateNext = state;
    rotate    = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) stateNext = REQ;
      end
      REQ: begin
        if (!(|req))   stateNext = IDLE;
        else if (HLDA) stateNext = GRANT;
      end
      GRANT: begin
        if (!HLDA) begin
          stateNext = IDLE;
        end else if (cycleDone && relNow) begin
          stateNext = IDLE;
          rotate    = priorityType;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    hrqNext      = (stateNext != IDLE);
    dackNext     = DACK;
    activeChNext = activeCh;
    chValidNext  = chValid;
    hiPtrNext    = hiPtr;
    if (state == REQ && stateNext == GRANT) begin
      dackNext         = '0;
      dackNext[winner] = 1'b1;
      activeChNext     = winner;
      chValidNext      = 1'b1;
    end
    if (stateNext == IDLE) begin
      dackNext    = '0;
      chValidNext = 1'b0;
    end
    if (rotate) hiPtrNext = activeCh + CHW'(1);
  end

endmodule

// File: tb/tb_dma_service_scheduler.sv
// Directed self-checking bench for dma_service_scheduler (NUM_CH=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_dma_service_scheduler;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [3:0] DREQ = '0;
  logic [3:0] maskReg = '0;
  logic       priorityType = 1'b0;
  logic [7:0] modeReg = 8'h55;
  logic       HLDA = 1'b0;
  logic       cycleDone = 1'b0;
  logic       tcReached = 1'b0;
  logic       HRQ;
  logic [3:0] DACK;
  logic [1:0] activeCh;
  logic       chValid;

  int nCmp = 0;
  int nBad = 0;

  dma_service_scheduler #(.NUM_CH(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .maskReg(maskReg),
    .priorityType(priorityType), .modeReg(modeReg), .HLDA(HLDA),
    .cycleDone(cycleDone), .tcReached(tcReached), .HRQ(HRQ),
    .DACK(DACK), .activeCh(activeCh), .chValid(chValid)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    RESET_N = 1'b0;
    DREQ = '0; maskReg = '0; HLDA = 1'b0;
    cycleDone = 1'b0; tcReached = 1'b0;
    priorityType = 1'b0; modeReg = 8'h55;
    repeat (2) tick();
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (2) tick();
    nCmp++;
    if ({HRQ, DACK, activeCh, chValid} !== 8'h00) begin
      nBad++;
      $display("FAIL reset_outputs got HRQ=%b DACK=%b ch=%0d v=%b want all 0",
               HRQ, DACK, activeCh, chValid);
    end
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic test_fixed_single();
    doReset();
    DREQ = 4'b1010;
    tick();
    nCmp++;
    if (HRQ !== 1'b1 || DACK !== 4'b0000) begin
      nBad++;
      $display("FAIL fixed_hrq got HRQ=%b DACK=%b want 1/0000", HRQ, DACK);
    end
    tick();
    nCmp++;
    if (HRQ !== 1'b1 || DACK !== 4'b0000) begin
      nBad++;
      $display("FAIL fixed_wait got HRQ=%b DACK=%b want 1/0000", HRQ, DACK);
    end
    HLDA = 1'b1;
    tick();
    nCmp++;
    if (DACK !== 4'b0010 || activeCh !== 2'd1 || chValid !== 1'b1) begin
      nBad++;
      $display("FAIL fixed_grant1 got DACK=%b ch=%0d v=%b want 0010/1/1",
               DACK, activeCh, chValid);
    end
    cycleDone = 1'b1;
    tick();
    cycleDone = 1'b0; HLDA = 1'b0; DREQ = 4'b1000;
    nCmp++;
    if (DACK !== 4'b0000 || HRQ !== 1'b0 || chValid !== 1'b0) begin
      nBad++;
      $display("FAIL fixed_release1 got DACK=%b HRQ=%b v=%b want 0000/0/0",
               DACK, HRQ, chValid);
    end
    tick();
    HLDA = 1'b1;
    tick();
    nCmp++;
    if (DACK !== 4'b1000 || activeCh !== 2'd3) begin
      nBad++;
      $display("FAIL fixed_grant2 got DACK=%b ch=%0d want 1000/3", DACK, activeCh);
    end
    cycleDone = 1'b1;
    tick();
    cycleDone = 1'b0; HLDA = 1'b0; DREQ = '0;
    tick();
  endtask

  task automatic test_rotating();
    doReset();
    priorityType = 1'b1;
    DREQ = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick();
      HLDA = 1'b1;
      tick();
      nCmp++;
      if (activeCh !== 2'(k % 4) || DACK !== 4'(1 << (k % 4))) begin
        nBad++;
        $display("FAIL rotate_%0d got ch=%0d DACK=%b want ch=%0d",
                 k, activeCh, DACK, k % 4);
      end
      cycleDone = 1'b1;
      tick();
      cycleDone = 1'b0; HLDA = 1'b0;
    end
    DREQ = '0;
    tick();
  endtask

  task automatic test_block();
    doReset();
    modeReg = 8'h65;
    DREQ = 4'b0100;
    tick();
    HLDA = 1'b1;
    tick();
    for (int c = 1; c <= 3; c++) begin
      tick();
      cycleDone = 1'b1;
      tcReached = (c == 3);
      tick();
      cycleDone = 1'b0; tcReached = 1'b0;
      nCmp++;
      if (c < 3 && DACK !== 4'b0100) begin
        nBad++;
        $display("FAIL block_hold%0d got DACK=%b want 0100", c, DACK);
      end else if (c == 3 && (DACK !== 4'b0000 || HRQ !== 1'b0)) begin
        nBad++;
        $display("FAIL block_release got DACK=%b HRQ=%b want 0000/0", DACK, HRQ);
      end
    end
    HLDA = 1'b0; DREQ = '0;
    tick();
  endtask

  task automatic test_demand();
    doReset();
    modeReg = 8'h51;
    DREQ = 4'b0010;
    tick();
    HLDA = 1'b1;
    tick();
    cycleDone = 1'b1;
    tick();
    cycleDone = 1'b0;
    nCmp++;
    if (DACK !== 4'b0010) begin
      nBad++;
      $display("FAIL demand_hold got DACK=%b want 0010", DACK);
    end
    DREQ = 4'b0000;
    tick();
    nCmp++;
    if (DACK !== 4'b0010) begin
      nBad++;
      $display("FAIL demand_drop_wait got DACK=%b want 0010", DACK);
    end
    cycleDone = 1'b1;
    tick();
    cycleDone = 1'b0; HLDA = 1'b0;
    nCmp++;
    if (DACK !== 4'b0000 || HRQ !== 1'b0) begin
      nBad++;
      $display("FAIL demand_release got DACK=%b HRQ=%b want 0000/0", DACK, HRQ);
    end
    tick();
  endtask

  task automatic test_abort();
    doReset();
    priorityType = 1'b1;
    DREQ = 4'b0100;
    tick();
    HLDA = 1'b1;
    tick();
    cycleDone = 1'b1;
    tick();
    cycleDone = 1'b0; HLDA = 1'b0; DREQ = 4'b1111;
    tick();
    HLDA = 1'b1;
    tick();
    nCmp++;
    if (activeCh !== 2'd3 || DACK !== 4'b1000) begin
      nBad++;
      $display("FAIL abort_pre got ch=%0d DACK=%b want 3/1000", activeCh, DACK);
    end
    HLDA = 1'b0; cycleDone = 1'b1;
    tick();
    cycleDone = 1'b0;
    nCmp++;
    if (DACK !== 4'b0000 || HRQ !== 1'b0) begin
      nBad++;
      $display("FAIL abort_drop got DACK=%b HRQ=%b want 0000/0", DACK, HRQ);
    end
    tick();
    HLDA = 1'b1;
    tick();
    nCmp++;
    if (activeCh !== 2'd3 || DACK !== 4'b1000) begin
      nBad++;
      $display("FAIL abort_regrant got ch=%0d DACK=%b want 3/1000", activeCh, DACK);
    end
    cycleDone = 1'b1;
    tick();
    cycleDone = 1'b0; HLDA = 1'b0; DREQ = '0;
    tick();
  endtask

  task automatic test_mask_reset();
    doReset();
    maskReg = 4'b0001; DREQ = 4'b0001;
    cycleDone = 1'b1; tcReached = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      nCmp++;
      if (HRQ !== 1'b0 || DACK !== 4'b0000) begin
        nBad++;
        $display("FAIL mask_%0d got HRQ=%b DACK=%b want 0/0000", k, HRQ, DACK);
      end
    end
    cycleDone = 1'b0; tcReached = 1'b0;
    maskReg = '0; DREQ = 4'b0010;
    tick();
    nCmp++;
    if (HRQ !== 1'b1) begin
      nBad++;
      $display("FAIL withdraw_hrq got HRQ=%b want 1", HRQ);
    end
    DREQ = '0;
    tick();
    nCmp++;
    if (HRQ !== 1'b0) begin
      nBad++;
      $display("FAIL withdraw_idle got HRQ=%b want 0", HRQ);
    end
    DREQ = 4'b0010;
    tick();
    HLDA = 1'b1;
    tick();
    nCmp++;
    if (DACK !== 4'b0010 || chValid !== 1'b1) begin
      nBad++;
      $display("FAIL prereset_grant got DACK=%b v=%b want 0010/1", DACK, chValid);
    end
    #2;
    RESET_N = 1'b0;
    #1;
    nCmp++;
    if ({HRQ, DACK, activeCh, chValid} !== 8'h00) begin
      nBad++;
      $display("FAIL async_reset got HRQ=%b DACK=%b ch=%0d v=%b want all 0",
               HRQ, DACK, activeCh, chValid);
    end
    DREQ = '0; HLDA = 1'b0;
    tick();
    RESET_N = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_fixed_single();
    test_rotating();
    test_block();
    test_demand();
    test_abort();
    test_mask_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
